sc_bernstein_eval: RTL

SC_BERNSTEIN_EVAL -- requirements
Module: sc_bernstein_eval

---
 rtl/sc_bernstein_eval.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sc_bernstein_eval.sv
// Stochastic Bernstein polynomial evaluator: popcount of the input stream bits selects
// a coefficient, which is compared against an LFSR to produce the output stochastic bit.
module sc_bernstein_eval #(
    parameter int unsigned DEGREE = 3,
    parameter int unsigned CW     = 6,
    parameter int unsigned LW     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_addr,
    input  logic [CW-1:0]     cfg_data,
    input  logic [CW-1:0]     seed,
    input  logic [LW-1:0]     len,
    input  logic              start,
    input  logic              x_valid,
    input  logic [DEGREE-1:0] x,
    output logic              z_valid,
    output logic              z,
    output logic              busy,
    output logic              done,
    output logic [LW-1:0]     count
);

    typedef enum logic {IDLE, RUN} state_t;

    // Feedback tap masks (bit n-1 set for 1-indexed tap n), chosen for maximal length.
    localparam logic [7:0] TAPS = (CW == 4) ? 8'h0C :
                                  (CW == 5) ? 8'h14 :
                                  (CW == 6) ? 8'h30 :
                                  (CW == 7) ? 8'h60 : 8'hB8;

    state_t          state_q, state_d;
    logic [CW-1:0]   coef_q [DEGREE+1];
    logic [CW-1:0]   coef_d [DEGREE+1];
    logic [CW-1:0]   lfsr_q, lfsr_d;
    logic [LW-1:0]   rem_q, rem_d;
    logic [LW-1:0]   count_q, count_d;
    logic            z_q, z_d;
    logic            zv_q, zv_d;
    logic            done_q, done_d;

    logic [2:0]      k;
    logic [CW-1:0]   c_sel;
    logic            z_next;

    function automatic logic [CW-1:0] lfsr_step(input logic [CW-1:0] v);
        logic fb;
        fb = ^(v & TAPS[CW-1:0]);
        return {v[CW-2:0], fb};
    endfunction

    always_comb begin
        k = '0;
        for (int unsigned i = 0; i < DEGREE; i++) begin
            k = k + 3'(x[i]);
        end
        c_sel = '0;
        for (int unsigned i = 0; i <= DEGREE; i++) begin
            if (k == 3'(i)) c_sel = coef_q[i];
        end
        z_next = (lfsr_q < c_sel);
    end

    always_comb begin
        state_d = state_q;
        coef_d  = coef_q;
        lfsr_d  = lfsr_q;
        rem_d   = rem_q;
        count_d = count_q;
        z_d     = z_q;
        zv_d    = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    for (int unsigned i = 0; i <= DEGREE; i++) begin
                        if (cfg_addr == 3'(i)) coef_d[i] = cfg_data;
                    end
                end
                if (start) begin
                    count_d = '0;
                    if (len != '0) begin
                        rem_d   = len;
                        lfsr_d  = (seed == '0) ? CW'(1) : seed;
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (x_valid) begin
                    z_d     = z_next;
                    zv_d    = 1'b1;
                    lfsr_d  = lfsr_step(lfsr_q);
                    rem_d   = rem_q - LW'(1);
                    count_d = count_q + LW'(z_next);
                    if (rem_q == LW'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            for (int unsigned i = 0; i <= DEGREE; i++) coef_q[i] <= '0;
            lfsr_q  <= CW'(1);
            rem_q   <= '0;
            count_q <= '0;
            z_q     <= 1'b0;
            zv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            for (int unsigned i = 0; i <= DEGREE; i++) coef_q[i] <= coef_d[i];
            lfsr_q  <= lfsr_d;
            rem_q   <= rem_d;
            count_q <= count_d;
            z_q     <= z_d;
            zv_q    <= zv_d;
            done_q  <= done_d;
        end
    end

    assign z_valid = zv_q;
    assign z       = z_q;
    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign count   = count_q;

endmodule
